icache_mem_responder: RTL and testbench
=======================================

Name: icache_mem_responder

Overview:
- Memory-side responder for the SM instruction-cache miss interface.
- Accepts block-refill requests (source, block address) from an instruction cache and queues them in a request FIFO.
- Reads each block word-by-word from a word-wide backing-memory read port and assembles the full block.
- Returns one response beat (source, block address, block data) on the cache's memory-response channel. One request is in service at a time; responses are in request order.

Parameters:
- XLEN, 32, data/address word width.
- BLOCKWORDS, 8, words per cache block; power of two, ≥2.
- SRC_BITS, 3, request source (warp id) width.
- REQ_DEPTH, 4, request FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  refill request valid.
- req_ready_o  out  1  request FIFO can accept.
- req_source_i  in  SRC_BITS  requester id (a_source).
- req_addr_i  in  XLEN  request address (a_addr).
- rsp_valid_o  out  1  refill response valid.
- rsp_ready_i  in  1  cache accepts response.
- rsp_source_o  out  SRC_BITS  echoed source (d_source).
- rsp_addr_o  out  XLEN  block-aligned address (d_addr).
- rsp_data_o  out  BLOCKWORDS*XLEN  block data; word i at [i*XLEN +: XLEN], word 0 = lowest address.
- mem_rd_valid_o  out  1  backing-memory word read request.
- mem_rd_ready_i  in  1  backing memory accepts read.
- mem_rd_addr_o  out  XLEN  byte address of word read.
- mem_rd_rvalid_i  in  1  read data return, in order, ≥1 cycle after accept.
- mem_rd_rdata_i  in  XLEN  returned word.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset: asynchronous and active-low, on rst_n with clock clk. FIFO empties, FSM goes to IDLE, counters and buffers clear. rsp_valid_o=0, mem_rd_valid_o=0, rsp_*/mem_rd_addr_o=0, err_o=0. req_ready_o=1 once reset is released. Reset mid-fill drops all queued and in-flight work; later mem_rd_rvalid_i pulses for dropped reads set err_o.
- Request FIFO: a push happens on req_valid_i&&req_ready_o. req_ready_o = !full, derived from the registered count. There is no bypass: when full, req_ready_o stays 0 even in a pop cycle. A push and pop in the same cycle are both legal when not full, and the count is unchanged.
- Base address: req_addr_i with the low log2(BLOCKWORDS*XLEN/8) bits cleared.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head, latch source and base, set issue_cnt=ret_cnt=0, go to FILL.
  - FILL:
    - mem_rd_valid_o = (issue_cnt<BLOCKWORDS).
    - mem_rd_addr_o = base + issue_cnt*(XLEN/8), modulo 2^XLEN (wraps).
    - issue_cnt increments on mem_rd_valid_o&&mem_rd_ready_i.
    - Each mem_rd_rvalid_i writes word ret_cnt into the block buffer and increments ret_cnt.
    - When the last word (ret_cnt==BLOCKWORDS-1) returns, go to RESP.
    - Issue and return may occur in the same cycle.
  - RESP: rsp_valid_o=1. rsp_source_o, rsp_addr_o and rsp_data_o stay stable until rsp_ready_i. On fire, go to IDLE. This leaves one IDLE bubble between responses.
- Counters are $clog2(BLOCKWORDS)+1 bits wide and never exceed BLOCKWORDS.
- Latency: with a request accepted in cycle T into an empty FIFO, and memory always ready with 1-cycle return:
  - the pop occurs in T+1;
  - the first mem_rd_valid_o is in T+2;
  - the last issue is in T+1+BLOCKWORDS;
  - rsp_valid_o is first high in T+3+BLOCKWORDS (T+11 for BLOCKWORDS=8).
- Error: mem_rd_rvalid_i outside FILL, or with ret_cnt==BLOCKWORDS, is ignored (the buffer is not written) and sets err_o. err_o clears only on reset.
- Requests with different sources are serviced strictly in arrival order. There is no merging of duplicate addresses; the cache MSHR handles that.

Test Plan:
- Single request, source=5, addr=0x0000_1064, memory returns word k = 0xA000_0000+k one cycle after accept.
  - mem_rd_addr_o is 0x1060..0x107C in order.
  - rsp_valid_o is first high at T+11 with rsp_source_o=5, rsp_addr_o=0x1060, and rsp_data_o word k = 0xA000_000k.
- Backpressure: mem_rd_ready_i low on alternate cycles and rsp_ready_i held low for 5 cycles.
  - Addresses are not skipped or repeated.
  - Response fields stay stable until fire.
  - Exactly one response is produced.
- FIFO full: push 5 back-to-back requests while the first is stalled in RESP.
  - req_ready_o drops after the 4th push and returns after the first FIFO pop.
  - All 5 responses come back in order with the correct sources.
- Wrap: addr=0xFFFF_FFE0 gives mem_rd_addr_o 0xFFFF_FFE0..0xFFFF_FFFC and rsp_addr_o=0xFFFF_FFE0.
  - For BLOCKWORDS=16 the block base is 0xFFFF_FFC0 and the addresses run to 0xFFFF_FFFC.
- Spurious return: mem_rd_rvalid_i pulsed while in IDLE sets err_o=1 and leaves buffer contents unaffected (checked on the next response).
- Reset mid-FILL after 3 returns: the outputs clear immediately.
  - A fresh request after reset produces a correct response using only post-reset data.

Source files
------------

// File: rtl/icache_mem_responder.sv
// icache_mem_responder
//   Memory-side responder for the instruction-cache miss interface. Block
//   refill requests are queued in a small FIFO and served one at a time. Each
//   block is read word by word from a backing-memory read port, assembled in a
//   block buffer, and returned as a single response beat. Responses leave in
//   request order.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*             refill request (valid/ready, source, address)
//   rsp_*             refill response (valid/ready, source, block address, block data)
//   mem_rd_*          backing-memory word read: request (valid/ready/addr),
//                     in-order data return (rvalid/rdata)
//   err_o             sticky flag: read data returned when none was outstanding
module icache_mem_responder #(
  parameter int XLEN       = 32,
  parameter int BLOCKWORDS = 8,
  parameter int SRC_BITS   = 3,
  parameter int REQ_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [SRC_BITS-1:0]        req_source_i,
  input  logic [XLEN-1:0]            req_addr_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [SRC_BITS-1:0]        rsp_source_o,
  output logic [XLEN-1:0]            rsp_addr_o,
  output logic [BLOCKWORDS*XLEN-1:0] rsp_data_o,
  output logic                       mem_rd_valid_o,
  input  logic                       mem_rd_ready_i,
  output logic [XLEN-1:0]            mem_rd_addr_o,
  input  logic                       mem_rd_rvalid_i,
  input  logic [XLEN-1:0]            mem_rd_rdata_i,
  output logic                       err_o
);

  localparam int CW   = $clog2(BLOCKWORDS) + 1;       // counter width, holds 0..BLOCKWORDS
  localparam int WIDX = $clog2(BLOCKWORDS);           // word index width
  localparam int PW   = $clog2(REQ_DEPTH);            // FIFO pointer width
  localparam int OFF  = $clog2(BLOCKWORDS * XLEN / 8); // byte offset bits inside a block
  localparam int BSH  = $clog2(XLEN / 8);             // byte offset bits inside a word

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // ---------------------------------------------------------------- request FIFO
  logic [SRC_BITS-1:0] fifo_src_q  [REQ_DEPTH];
  logic [XLEN-1:0]     fifo_base_q [REQ_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PW:0]         count_q;
  logic                full, empty, push, pop;
  logic [1:0]          state_q, state_d;

  assign full        = (count_q == (PW+1)'(REQ_DEPTH));
  assign empty       = (count_q == '0);
  // Ready comes only from the registered count: no bypass when full.
  assign req_ready_o = !full;
  assign push        = req_valid_i && !full;
  assign pop         = (state_q == S_IDLE) && !empty;

  // Storage needs no reset: entries are only read when the count says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_src_q[wr_ptr_q]  <= req_source_i;
      fifo_base_q[wr_ptr_q] <= {req_addr_i[XLEN-1:OFF], {OFF{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- fill engine
  logic [CW-1:0]       issue_cnt_q, ret_cnt_q;
  logic [SRC_BITS-1:0] src_q;
  logic [XLEN-1:0]     base_q;
  logic                err_q;
  logic                in_fill, issue, ret_ok, ret_bad, last_ret;

  assign in_fill  = (state_q == S_FILL);
  assign issue    = mem_rd_valid_o && mem_rd_ready_i;
  // A return is only usable while filling and while a word slot is still open.
  assign ret_ok   = in_fill && mem_rd_rvalid_i && (ret_cnt_q != CW'(BLOCKWORDS));
  assign ret_bad  = mem_rd_rvalid_i && !ret_ok;
  assign last_ret = ret_ok && (ret_cnt_q == CW'(BLOCKWORDS - 1));

  assign mem_rd_valid_o = in_fill && (issue_cnt_q < CW'(BLOCKWORDS));
  // Word address wraps modulo 2^XLEN by plain truncating addition.
  assign mem_rd_addr_o  = in_fill ? (base_q + (XLEN'(issue_cnt_q) << BSH)) : '0;

  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_source_o = src_q;
  assign rsp_addr_o   = base_q;
  assign err_o        = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty)     state_d = S_FILL;
      S_FILL:  if (last_ret)   state_d = S_RESP;
      S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      src_q       <= '0;
      base_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        src_q       <= fifo_src_q[rd_ptr_q];
        base_q      <= fifo_base_q[rd_ptr_q];
        issue_cnt_q <= '0;
        ret_cnt_q   <= '0;
      end else begin
        if (issue)  issue_cnt_q <= issue_cnt_q + CW'(1);
        if (ret_ok) ret_cnt_q   <= ret_cnt_q + CW'(1);
      end
      if (ret_bad) err_q <= 1'b1;
    end
  end

  // One register per block word; returned data lands in slot ret_cnt.
  for (genvar gi = 0; gi < BLOCKWORDS; gi++) begin : g_word
    logic [XLEN-1:0] word_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_q <= '0;
      end else if (ret_ok && (ret_cnt_q[WIDX-1:0] == WIDX'(gi))) begin
        word_q <= mem_rd_rdata_i;
      end
    end
    assign rsp_data_o[gi*XLEN +: XLEN] = word_q;
  end

endmodule

// File: tb/tb_icache_mem_responder.sv
`timescale 1ns/1ps
module tb_icache_mem_responder;
  localparam int XLEN = 32, BW = 8, SB = 3, DEPTH = 4;
  localparam int DW = BW * XLEN;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            req_valid_i = 1'b0, req_ready_o;
  logic [SB-1:0]   req_source_i = '0;
  logic [XLEN-1:0] req_addr_i = '0;
  logic            rsp_valid_o, rsp_ready_i;
  logic [SB-1:0]   rsp_source_o;
  logic [XLEN-1:0] rsp_addr_o;
  logic [DW-1:0]   rsp_data_o;
  logic            mem_rd_valid_o, mem_rd_ready_i;
  logic [XLEN-1:0] mem_rd_addr_o;
  logic            mem_rd_rvalid_i;
  logic [XLEN-1:0] mem_rd_rdata_i;
  logic            err_o;

  icache_mem_responder #(.XLEN(XLEN), .BLOCKWORDS(BW), .SRC_BITS(SB), .REQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_source_i(req_source_i), .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_source_o(rsp_source_o), .rsp_addr_o(rsp_addr_o), .rsp_data_o(rsp_data_o),
    .mem_rd_valid_o(mem_rd_valid_o), .mem_rd_ready_i(mem_rd_ready_i),
    .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_rvalid_i(mem_rd_rvalid_i),
    .mem_rd_rdata_i(mem_rd_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  // Scoreboard: expected responses and expected memory read addresses.
  logic [SB-1:0]   exp_src  [$];
  logic [XLEN-1:0] exp_addr [$];
  logic [DW-1:0]   exp_data [$];
  logic [XLEN-1:0] exp_mem  [$];
  // Backing-memory model: pending returns, in order.
  logic [XLEN-1:0] ret_data [$];
  int              ret_due  [$];
  int              last_due = 0;

  // Environment knobs (written only by the main sequence).
  bit              k_mode = 1'b0;
  logic [XLEN-1:0] salt = 32'h1234_5678;
  int              mem_mode = 0;          // 0 always ready, 1 alternate, 2 random
  int              ret_extra_max = 0;
  bit              rsp_rand = 1'b0;
  int              rsp_block_until = 0;
  int              spur_cyc = -1;
  int              acc_cyc = 0;

  // Written only by the env / monitor processes.
  int n_returns = 0, n_fires = 0, mem_rise_cyc = -1, rsp_rise_cyc = -1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event did not occur within its bound", name);
  endtask

  // Contents of the backing memory: a pure function of the byte address.
  function automatic logic [XLEN-1:0] data_of(input logic [XLEN-1:0] a);
    if (k_mode) return 32'hA000_0000 + ((a >> 2) & 32'h7);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Reference model: block base, the word addresses read, and the assembled block.
  task automatic expect_req(input logic [SB-1:0] src, input logic [XLEN-1:0] addr);
    logic [XLEN-1:0] mask, base, a;
    logic [DW-1:0]   d;
    mask = XLEN'(BW * XLEN / 8 - 1);
    base = addr & ~mask;
    d = '0;
    for (int k = 0; k < BW; k++) begin
      a = base + XLEN'(k * (XLEN / 8));
      exp_mem.push_back(a);
      d[k*XLEN +: XLEN] = data_of(a);
    end
    exp_src.push_back(src);
    exp_addr.push_back(base);
    exp_data.push_back(d);
  endtask

  task automatic flush_all();
    exp_src.delete(); exp_addr.delete(); exp_data.delete(); exp_mem.delete();
    ret_data.delete(); ret_due.delete(); last_due = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the request is accepted.
  task automatic send(input logic [SB-1:0] src, input logic [XLEN-1:0] addr);
    int n = 0;
    req_valid_i = 1'b1; req_source_i = src; req_addr_i = addr;
    forever begin
      @(negedge clk);
      if (req_ready_o) begin
        expect_req(src, addr);
        acc_cyc = cyc;
        break;
      end
      if (++n > 2000) begin fail_now("req_accept"); break; end
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_src.size() != 0 || exp_mem.size() != 0 || ret_due.size() != 0) begin
      @(posedge clk);
      if (++n > 5000) begin fail_now(name); flush_all(); break; end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_valid(input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid_o) break;
      if (++n > 2000) begin fail_now(name); break; end
    end
  endtask

  // Environment: drives memory ready, read returns and response ready after each edge.
  initial begin
    mem_rd_ready_i = 1'b0; rsp_ready_i = 1'b0; mem_rd_rvalid_i = 1'b0; mem_rd_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      case (mem_mode)
        0:       mem_rd_ready_i = 1'b1;
        1:       mem_rd_ready_i = ~mem_rd_ready_i;
        default: mem_rd_ready_i = ($urandom_range(0, 99) < 60);
      endcase
      rsp_ready_i = (cyc < rsp_block_until) ? 1'b0 : (rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
        mem_rd_rvalid_i = 1'b1;
        mem_rd_rdata_i  = ret_data.pop_front();
        void'(ret_due.pop_front());
        n_returns++;
      end else if (cyc == spur_cyc) begin
        mem_rd_rvalid_i = 1'b1;
        mem_rd_rdata_i  = 32'hDEAD_BEEF;
      end else begin
        mem_rd_rvalid_i = 1'b0;
      end
    end
  end

  // Monitor: memory read addresses, response stability and response contents.
  initial begin
    bit              prev_rv = 0, prev_fire = 0, prev_mv = 0;
    logic [SB-1:0]   sv_src = '0;
    logic [XLEN-1:0] sv_addr = '0;
    logic [DW-1:0]   sv_data = '0;
    int              due;
    forever begin
      @(negedge clk);
      if (!rst_n) begin prev_rv = 0; prev_fire = 0; prev_mv = 0; continue; end
      if (mem_rd_valid_o && !prev_mv) mem_rise_cyc = cyc;
      prev_mv = mem_rd_valid_o;
      if (mem_rd_valid_o && mem_rd_ready_i) begin
        if (exp_mem.size() == 0) begin
          tests++; fails++;
          $display("FAIL mem_rd_unexpected: got addr %0h, expected no read", mem_rd_addr_o);
        end else begin
          chk("mem_rd_addr", mem_rd_addr_o, exp_mem.pop_front());
        end
        due = cyc + 1 + $urandom_range(0, ret_extra_max);
        if (due < last_due) due = last_due;
        last_due = due;
        ret_due.push_back(due);
        ret_data.push_back(data_of(mem_rd_addr_o));
      end
      if (prev_rv && !prev_fire) begin
        chk("rsp_hold_ctrl", {rsp_valid_o, rsp_source_o, rsp_addr_o}, {1'b1, sv_src, sv_addr});
        chk("rsp_hold_data", rsp_data_o, sv_data);
      end
      if (rsp_valid_o && !prev_rv) rsp_rise_cyc = cyc;
      if (rsp_valid_o && rsp_ready_i) begin
        n_fires++;
        if (exp_src.size() == 0) begin
          tests++; fails++;
          $display("FAIL rsp_unexpected: got source %0d addr %0h, expected no response", rsp_source_o, rsp_addr_o);
        end else begin
          chk("rsp_source", rsp_source_o, exp_src.pop_front());
          chk("rsp_addr", rsp_addr_o, exp_addr.pop_front());
          chk("rsp_data", rsp_data_o, exp_data.pop_front());
        end
      end
      prev_rv = rsp_valid_o; prev_fire = rsp_valid_o && rsp_ready_i;
      sv_src = rsp_source_o; sv_addr = rsp_addr_o; sv_data = rsp_data_o;
    end
  end

  initial begin
    int n, f0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {rsp_valid_o, mem_rd_valid_o, err_o, rsp_addr_o, mem_rd_addr_o}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", req_ready_o, 1'b1);
    @(posedge clk); #1;

    // Single request with the 0xA000_000k memory pattern and latency check
    k_mode = 1'b1;
    send(3'd5, 32'h0000_1064);
    wait_drain("single_drain");
    chk("lat_first_issue", 32'(mem_rise_cyc - acc_cyc), 32'd2);
    chk("lat_first_rsp", 32'(rsp_rise_cyc - acc_cyc), 32'(BW + 3));
    chk("err_clean_single", err_o, 1'b0);
    k_mode = 1'b0;

    // Backpressure: memory ready on alternate cycles, response held off 5 cycles
    salt = $urandom; mem_mode = 1; rsp_block_until = 32'h7FFF_FFFF;
    f0 = n_fires;
    send(3'd2, $urandom);
    wait_rsp_valid("bp_rsp_valid");
    rsp_block_until = cyc + 6;
    wait_drain("bp_drain");
    chk("bp_one_response", 32'(n_fires - f0), 32'd1);

    // FIFO full while the first request sits in its response state
    mem_mode = 0; rsp_block_until = 32'h7FFF_FFFF;
    send(3'd1, $urandom);
    wait_rsp_valid("full_rsp_valid");
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) send(SB'(i + 2), $urandom);
    @(negedge clk);
    chk("full_ready_low", req_ready_o, 1'b0);
    fork
      send(3'd7, $urandom);
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("full_ready_held", req_ready_o, 1'b0);
        rsp_block_until = 0;
      end
    join
    wait_drain("full_drain");

    // Wrap at the top of the address space
    send(3'd6, 32'hFFFF_FFE0);
    wait_drain("wrap_drain");

    // Randomized traffic with random memory and response backpressure
    mem_mode = 2; ret_extra_max = 2; rsp_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(SB'($urandom), ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | $urandom_range(0, 255)) : $urandom);
      n = $urandom_range(0, 3);
      repeat (n) begin @(posedge clk); #1; end
    end
    wait_drain("rand_drain");
    chk("err_clean_rand", err_o, 1'b0);

    // Spurious return while idle
    mem_mode = 0; ret_extra_max = 0; rsp_rand = 1'b0;
    spur_cyc = cyc + 2;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("err_spurious", err_o, 1'b1);
    @(posedge clk); #1;
    send(3'd4, $urandom);
    wait_drain("spur_drain");

    // Reset after three returns of a fill
    n = n_returns;
    send(3'd3, $urandom);
    f0 = 0;
    while (n_returns - n < 3) begin
      @(posedge clk); #2;
      if (++f0 > 200) begin fail_now("reset_fill_returns"); break; end
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midfill_reset_outputs", {rsp_valid_o, mem_rd_valid_o, err_o, rsp_addr_o, mem_rd_addr_o, rsp_data_o}, '0);
    flush_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    salt = ~salt;
    @(posedge clk); #1;
    send(3'd0, $urandom);
    wait_drain("post_reset_drain");
    chk("err_after_reset", err_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
